approx_mul_err_accum: RTL and testbench

- Downstream evaluation stage for the 8x8 approximate multiplier.
- Consumes operand pairs and the approximate 16-bit product; computes the exact product internally.
- Accumulates error statistics over a programmed sample count: error count, sum of error distance, and maximum error distance with its operands.
- Used in hardware error-characterisation sweeps of the approximate multipliers on FPGA.

---
 rtl/approx_mul_err_accum.sv | 235 +++++++++++++++++++++++
 tb/tb_approx_mul_err_accum.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_accum.sv
// Error-statistics accumulator for an 8x8 approximate multiplier: error count, error-distance sum and worst case.
// Optional signed bias accumulator (err_bias output) is built when APPROX_ERR_BIAS_EN is defined.
module approx_mul_err_accum #(
   parameter int W     = 8,
   parameter int CNT_W = 17,
   parameter int SUM_W = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_samples,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic [2*W-1:0]     in_prod,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [SUM_W-1:0]   sum_ed,
   output logic [2*W-1:0]     max_ed,
   output logic [W-1:0]       max_a,
   output logic [W-1:0]       max_b
`ifdef APPROX_ERR_BIAS_EN
   ,
   output logic [SUM_W:0]     err_bias
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_lim_q;
   logic [CNT_W-1:0]  sample_cnt_q;
   logic [CNT_W-1:0]  sample_cnt_d;
   logic              drain_q;
   logic              done_q;

   logic              accept;
   logic              stat_clr;

   // ---------------------------------------------------------------------
   // Control: run state, sample counter and completion flag
   // ---------------------------------------------------------------------
   assign in_ready     = (state_q == ST_RUN) && (sample_cnt_q < cnt_lim_q);
   assign accept       = in_valid & in_ready;
   assign stat_clr     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign sample_cnt_d = sample_cnt_q + CNT_W'(1);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_lim_q    <= '0;
         sample_cnt_q <= '0;
         drain_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  cnt_lim_q    <= num_samples;
                  sample_cnt_q <= '0;
                  drain_q      <= 1'b0;
                  if (num_samples == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  sample_cnt_q <= sample_cnt_d;
                  if (sample_cnt_d == cnt_lim_q) begin
                     state_q <= ST_DRAIN;
                     drain_q <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // Two cycles let the last accepted sample clear S1 and land in the statistics.
               if (drain_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done       = done_q;
   assign sample_cnt = sample_cnt_q;

   // ---------------------------------------------------------------------
   // S1: operand / product capture with the exact reference product
   // ---------------------------------------------------------------------
   logic              s1_vld_q;
   logic [W-1:0]      s1_a_q;
   logic [W-1:0]      s1_b_q;
   logic [2*W-1:0]    s1_prod_q;
   logic [2*W-1:0]    s1_exact_q;
   logic [2*W-1:0]    exact_d;

   assign exact_d = (2*W)'(in_a) * (2*W)'(in_b);

   // NOTE: datapath registers are reset too, so a mid-run reset cannot leak stale samples into a new run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_prod_q  <= '0;
         s1_exact_q <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_prod_q  <= in_prod;
            s1_exact_q <= exact_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S2: error distance and statistics update
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0]  err_cnt_q;
   logic [SUM_W-1:0]  sum_ed_q;
   logic [2*W-1:0]    max_ed_q;
   logic [W-1:0]      max_a_q;
   logic [W-1:0]      max_b_q;

   logic [2*W-1:0]    ed_d;
   logic [SUM_W:0]    sum_ext_d;
   logic [SUM_W-1:0]  sum_ed_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ed_d      = '0;
      sum_ext_d = '0;
      sum_ed_d  = sum_ed_q;
      if (s1_exact_q >= s1_prod_q) begin
         ed_d = s1_exact_q - s1_prod_q;
      end else begin
         ed_d = s1_prod_q - s1_exact_q;
      end
      // A carry out of the sum saturates; once all-ones any further error re-saturates.
      sum_ext_d = {1'b0, sum_ed_q} + (SUM_W+1)'(ed_d);
      sum_ed_d  = sum_ext_d[SUM_W] ? {SUM_W{1'b1}} : sum_ext_d[SUM_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
         sum_ed_q  <= '0;
         max_ed_q  <= '0;
         max_a_q   <= '0;
         max_b_q   <= '0;
      end else if (stat_clr) begin
         err_cnt_q <= '0;
         sum_ed_q  <= '0;
         max_ed_q  <= '0;
         max_a_q   <= '0;
         max_b_q   <= '0;
      end else if (s1_vld_q) begin
         if (ed_d != '0) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
         sum_ed_q <= sum_ed_d;
         // Strict compare: on a tie the earlier sample keeps its operands.
         if (ed_d > max_ed_q) begin
            max_ed_q <= ed_d;
            max_a_q  <= s1_a_q;
            max_b_q  <= s1_b_q;
         end
      end
   end

   assign err_cnt = err_cnt_q;
   assign sum_ed  = sum_ed_q;
   assign max_ed  = max_ed_q;
   assign max_a   = max_a_q;
   assign max_b   = max_b_q;

`ifdef APPROX_ERR_BIAS_EN
   // ---------------------------------------------------------------------
   // Signed bias: running sum of (approx - exact), saturating both ways
   // ---------------------------------------------------------------------
   localparam logic [SUM_W:0] BIAS_MAX = {1'b0, {SUM_W{1'b1}}};
   localparam logic [SUM_W:0] BIAS_MIN = {1'b1, {SUM_W{1'b0}}};

   logic [SUM_W:0]    bias_q;
   logic [2*W:0]      diff_d;
   logic [SUM_W+1:0]  diff_ext_d;
   logic [SUM_W+1:0]  bias_ext_d;
   logic [SUM_W:0]    bias_d;

   always_comb begin
      diff_d     = {1'b0, s1_prod_q} - {1'b0, s1_exact_q};
      diff_ext_d = {{(SUM_W+1-2*W){diff_d[2*W]}}, diff_d};
      bias_ext_d = {bias_q[SUM_W], bias_q} + diff_ext_d;
      bias_d     = bias_ext_d[SUM_W:0];
      if (bias_ext_d[SUM_W+1] != bias_ext_d[SUM_W]) begin
         bias_d = bias_ext_d[SUM_W+1] ? BIAS_MIN : BIAS_MAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_q <= '0;
      end else if (stat_clr) begin
         bias_q <= '0;
      end else if (s1_vld_q) begin
         bias_q <= bias_d;
      end
   end

   assign err_bias = bias_q;
`endif

endmodule

// File: tb/tb_approx_mul_err_accum.sv
// Scoreboard bench for approx_mul_err_accum: a bench-side model predicts run statistics, checked at done.
// Built with SUM_W = 17 so the saturation case is reachable in a few samples.
module tb_approx_mul_err_accum;

   localparam int W     = 8;
   localparam int CNT_W = 17;
   localparam int SUM_W = 17;

   localparam longint SUM_MAX  = (longint'(1) << SUM_W) - 1;
   localparam longint BIAS_MAX = (longint'(1) << SUM_W) - 1;
   localparam longint BIAS_MIN = -(longint'(1) << SUM_W);

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CNT_W-1:0]  num_samples;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_a;
   logic [W-1:0]      in_b;
   logic [2*W-1:0]    in_prod;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic [SUM_W-1:0]  sum_ed;
   logic [2*W-1:0]    max_ed;
   logic [W-1:0]      max_a;
   logic [W-1:0]      max_b;
`ifdef APPROX_ERR_BIAS_EN
   logic signed [SUM_W:0] err_bias;
`endif

   approx_mul_err_accum #(
      .W     (W),
      .CNT_W (CNT_W),
      .SUM_W (SUM_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_prod     (in_prod),
      .busy        (busy),
      .done        (done),
      .sample_cnt  (sample_cnt),
      .err_cnt     (err_cnt),
      .sum_ed      (sum_ed),
      .max_ed      (max_ed),
      .max_a       (max_a),
      .max_b       (max_b)
`ifdef APPROX_ERR_BIAS_EN
      ,
      .err_bias    (err_bias)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected end-of-run statistics.
   typedef struct {
      longint cnt;
      longint err;
      longint sum;
      longint mx;
      longint ma;
      longint mb;
      longint bias;
   } exp_t;

   exp_t   sb_q[$];
   int     n_cmp;
   int     n_bad;

   longint m_cnt, m_err, m_sum, m_max, m_ma, m_mb, m_bias;

   task automatic check(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic model_clear();
      m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0; m_bias = 0;
   endtask

   task automatic model_beat(input int a, input int b, input int p);
      longint ex, ed;
      ex = longint'(a) * longint'(b);
      ed = (ex > p) ? ex - p : p - ex;
      m_cnt++;
      if (ed != 0) m_err++;
      m_sum = m_sum + ed;
      if (m_sum > SUM_MAX) m_sum = SUM_MAX;
      if (ed > m_max) begin
         m_max = ed; m_ma = a; m_mb = b;
      end
      m_bias = m_bias + (longint'(p) - ex);
      if (m_bias > BIAS_MAX) m_bias = BIAS_MAX;
      if (m_bias < BIAS_MIN) m_bias = BIAS_MIN;
   endtask

   // Called at a falling edge; returns at the falling edge after the start edge.
   task automatic start_run(input int n);
      start       = 1'b1;
      num_samples = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      model_clear();
   endtask

   // Presents one beat and holds it until accepted; returns at the following falling edge.
   task automatic send(input int a, input int b, input int p);
      int guard;
      in_valid = 1'b1;
      in_a     = W'(a);
      in_b     = W'(b);
      in_prod  = (2*W)'(p);
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      model_beat(a, b, p);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push_expected();
      exp_t e;
      e.cnt = m_cnt; e.err = m_err; e.sum = m_sum; e.mx = m_max;
      e.ma = m_ma; e.mb = m_mb; e.bias = m_bias;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic check_run(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 0, 1);
         return;
      end
      e = sb_q.pop_front();
      check({tag, ".done"},       longint'(done),       1);
      check({tag, ".busy"},       longint'(busy),       0);
      check({tag, ".sample_cnt"}, longint'(sample_cnt), e.cnt);
      check({tag, ".err_cnt"},    longint'(err_cnt),    e.err);
      check({tag, ".sum_ed"},     longint'(sum_ed),     e.sum);
      check({tag, ".max_ed"},     longint'(max_ed),     e.mx);
      check({tag, ".max_a"},      longint'(max_a),      e.ma);
      check({tag, ".max_b"},      longint'(max_b),      e.mb);
`ifdef APPROX_ERR_BIAS_EN
      check({tag, ".err_bias"},   longint'(err_bias),   e.bias);
`endif
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".done"},       longint'(done),       0);
      check({tag, ".busy"},       longint'(busy),       0);
      check({tag, ".in_ready"},   longint'(in_ready),   0);
      check({tag, ".sample_cnt"}, longint'(sample_cnt), 0);
      check({tag, ".err_cnt"},    longint'(err_cnt),    0);
      check({tag, ".sum_ed"},     longint'(sum_ed),     0);
      check({tag, ".max_ed"},     longint'(max_ed),     0);
      check({tag, ".max_ab"},     longint'({max_a, max_b}), 0);
`ifdef APPROX_ERR_BIAS_EN
      check({tag, ".err_bias"},   longint'(err_bias),   0);
`endif
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      int n;
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; start = 1'b0; num_samples = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_prod = '0;
      model_clear();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Exact products: no error, done two cycles after the last accept.
      start_run(16);
      check("exact.busy", longint'(busy), 1);
      for (int i = 0; i < 16; i++) send(i, i, i * i);
      push_expected();
      check("exact.in_ready_low", longint'(in_ready), 0);
      wait_done(n);
      check("exact.done_latency", n, 2);
      check_run("exact");

      // Single worst-case error.
      start_run(1);
      send(255, 255, 0);
      push_expected();
      wait_done(n);
      check_run("large");

      // Distances 5, 9, 9, 2 with idle cycles between beats; tie keeps the 2nd sample.
      start_run(4);
      send(10, 10, 95);  @(negedge clk);
      send(3, 3, 18);    @(negedge clk);
      send(4, 4, 7);     @(negedge clk);
      check("tie.in_ready_before_last", longint'(in_ready), 1);
      send(2, 2, 6);
      check("tie.in_ready_after_last", longint'(in_ready), 0);
      push_expected();
      wait_done(n);
      check_run("tie");
      check("tie.max_a_is_3", longint'(max_a), 3);

      // Zero sample count: done immediately with cleared statistics.
      start_run(0);
      push_expected();
      wait_done(n);
      check("zero.done_latency", n, 0);
      check_run("zero");

      // Start pulsed mid-run is ignored.
      start_run(3);
      send(1, 2, 3);
      start = 1'b1; num_samples = CNT_W'(7);
      @(negedge clk);
      start = 1'b0;
      check("ignore.busy", longint'(busy), 1);
      send(7, 9, 60);
      send(12, 12, 144);
      push_expected();
      check("ignore.in_ready_low", longint'(in_ready), 0);
      wait_done(n);
      check_run("ignore");

      // Sum saturates on the third sample and stays saturated afterwards.
      start_run(4);
      send(255, 255, 0);
      send(255, 255, 0);
      send(255, 255, 0);
      send(1, 1, 11);
      push_expected();
      wait_done(n);
      check_run("sat");
      check("sat.sum_allones", longint'(sum_ed), SUM_MAX);
      repeat (3) @(negedge clk);
      check("sat.sum_stable", longint'(sum_ed), SUM_MAX);

      // Asynchronous reset in the middle of a run.
      start_run(10);
      for (int i = 0; i < 5; i++) send(i + 20, i + 3, i * 37);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_run(2);
      send(100, 200, 20000);
      send(17, 33, 600);
      push_expected();
      wait_done(n);
      check_run("after_reset");

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
